vect_serializer: RTL and testbench

- Takes one packed vector of `N_MAX elements and streams it out one element per handshake, element 0 first.
- It is the streaming counterpart of the parallel vector register stage. It feeds per-element consumers (scalar MAC / accumulate paths) from a parallel vector result.
- Runtime length n_len lets short vectors finish early without padding cycles.

---
 rtl/vect_serializer_pkg.sv | 12 +
 rtl/vect_serializer.sv | 92 +++++++++
 tb/tb_vect_serializer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/vect_serializer_pkg.sv
// Shared vector-datapath sizing: element count and the index/length width
// that the serializer, collector and vector register stages must agree on.
`ifndef N_MAX
`define N_MAX 4
`endif

package vect_serializer_pkg;

    localparam int N_MAX = `N_MAX;
    localparam int IDXW  = $clog2(N_MAX + 1);

endpackage

// File: rtl/vect_serializer.sv
// Streams one packed vector out element 0 first, one element per handshake,
// with a runtime length so short vectors finish without padding cycles.
module vect_serializer
    import vect_serializer_pkg::*;
#(
    parameter int WIDTH = 43
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_MAX*WIDTH-1:0] vect_in,
    input  logic [IDXW-1:0]        n_len,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       el_out,
    output logic [IDXW-1:0]        el_idx,
    output logic                   el_last,
    output logic                   busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [N_MAX*WIDTH-1:0] buf_q, buf_d;
    logic [IDXW-1:0]        rem_q, rem_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic                   rdy_q;

    logic                   accept;
    logic                   xfer;
    logic [IDXW-1:0]        len_eff;

    // rdy_q keeps in_ready low until the first clock after reset release.
    assign in_ready  = rdy_q && (state_q == IDLE);
    assign out_valid = (state_q == STREAM);
    assign busy      = (state_q == STREAM);
    assign el_out    = buf_q[WIDTH-1:0];
    assign el_idx    = idx_q;
    assign el_last   = out_valid && (rem_q == IDXW'(1));

    assign accept  = in_valid && in_ready;
    assign xfer    = out_valid && out_ready;
    assign len_eff = (n_len > IDXW'(N_MAX)) ? IDXW'(N_MAX) : n_len;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    buf_d = vect_in;
                    rem_d = len_eff;
                    idx_d = '0;
                    // A zero-length vector is swallowed without leaving IDLE.
                    if (len_eff != '0) state_d = STREAM;
                end
            end
            STREAM: begin
                if (xfer) begin
                    buf_d = buf_q >> WIDTH;
                    idx_d = idx_q + IDXW'(1);
                    rem_d = rem_q - IDXW'(1);
                    if (rem_q == IDXW'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            rdy_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vect_serializer.sv
// Scoreboard bench for vect_serializer with N_MAX=4, WIDTH=8.
module tb_vect_serializer;
    import vect_serializer_pkg::*;

    localparam int W = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [N_MAX*W-1:0] vect_in = '0;
    logic [IDXW-1:0]    n_len = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [W-1:0]       el_out;
    logic [IDXW-1:0]    el_idx;
    logic               el_last;
    logic               busy;

    vect_serializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .vect_in   (vect_in),
        .n_len     (n_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .el_out    (el_out),
        .el_idx    (el_idx),
        .el_last   (el_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]    el;
        logic [IDXW-1:0] idx;
        logic            last;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pe(input logic [W-1:0] el, input int idx, input logic last);
        exp_t x;
        x.el   = el;
        x.idx  = IDXW'(idx);
        x.last = last;
        q.push_back(x);
    endtask

    // Monitor: every completed transfer must match the head of the queue.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got el %0h idx %0d, expected no output", el_out, el_idx);
            end else begin
                e = q.pop_front();
                chk("el_out", 64'(el_out), 64'(e.el));
                chk("el_idx", 64'(el_idx), 64'(e.idx));
                chk("el_last", 64'(el_last), 64'(e.last));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accept edge.
    task automatic send(input logic [N_MAX*W-1:0] vec, input int len);
        int k;
        for (k = 0; k < 20; k++) begin
            if (in_ready) break;
            @(posedge clk); #1;
        end
        if (k == 20) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        vect_in  = vec;
        n_len    = IDXW'(len);
        @(posedge clk); #1;
        in_valid = 1'b0;
        vect_in  = 32'hA5A5_A5A5;
        n_len    = IDXW'(1);
    endtask

    task automatic drain(input int exp_cyc, input string nm);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 60 && out_valid; i++) begin
            cnt++;
            @(posedge clk); #1;
        end
        chk({nm, "_cycles"}, 64'(cnt), 64'(exp_cyc));
        chk({nm, "_in_ready_after"}, 64'(in_ready), 64'd1);
        chk({nm, "_queue_empty"}, 64'(q.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_el_out", 64'(el_out), 64'd0);
        chk("rst_el_idx", 64'(el_idx), 64'd0);
        chk("rst_el_last", 64'(el_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("rst_in_ready_held", 64'(in_ready), 64'd0);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Basic stream
        out_ready = 1'b1;
        pe(8'h11, 0, 0); pe(8'h22, 1, 0); pe(8'h33, 2, 0); pe(8'h44, 3, 1);
        send(32'h4433_2211, 4);
        chk("basic_latency_valid", 64'(out_valid), 64'd1);
        chk("basic_latency_el", 64'(el_out), 64'h11);
        chk("basic_busy", 64'(busy), 64'd1);
        chk("basic_in_ready_low", 64'(in_ready), 64'd0);
        drain(4, "basic");

        // Short vector
        pe(8'hAA, 0, 0); pe(8'hBB, 1, 1);
        send(32'hDDCC_BBAA, 2);
        drain(2, "short");

        // Backpressure
        out_ready = 1'b0;
        pe(8'h11, 0, 0); pe(8'h22, 1, 0); pe(8'h33, 2, 1);
        send(32'h4433_2211, 3);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_el", 64'(el_out), 64'h11);
            chk("bp_idx", 64'(el_idx), 64'd0);
            chk("bp_last", 64'(el_last), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drain(3, "bp");

        // Zero length: swallowed, no output
        send(32'h9988_7766, 0);
        for (int i = 0; i < 3; i++) begin
            chk("len0_valid", 64'(out_valid), 64'd0);
            chk("len0_in_ready", 64'(in_ready), 64'd1);
            chk("len0_busy", 64'(busy), 64'd0);
            @(posedge clk); #1;
        end

        // Oversize length clamps to N_MAX
        pe(8'h11, 0, 0); pe(8'h22, 1, 0); pe(8'h33, 2, 0); pe(8'h44, 3, 1);
        send(32'h4433_2211, 7);
        drain(4, "len7");

        // Offer during STREAM is ignored
        out_ready = 1'b0;
        pe(8'h55, 0, 0); pe(8'h66, 1, 0); pe(8'h77, 2, 0); pe(8'h88, 3, 1);
        send(32'h8877_6655, 4);
        chk("ign_in_ready_low", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        vect_in  = 32'hDEAD_BEEF;
        n_len    = IDXW'(4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("ign_el", 64'(el_out), 64'h55);
        chk("ign_idx", 64'(el_idx), 64'd0);
        out_ready = 1'b1;
        drain(4, "ignore");
        for (int i = 0; i < 3; i++) begin
            chk("ign_no_extra", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end

        // Async reset after the second transfer
        pe(8'h11, 0, 0); pe(8'h22, 1, 0); pe(8'h33, 2, 0); pe(8'h44, 3, 1);
        send(32'h4433_2211, 4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_el_before_rst", 64'(el_out), 64'h33);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_el", 64'(el_out), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        q.delete();
        #3 rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rel_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rel_valid", 64'(out_valid), 64'd0);
        pe(8'h0C, 0, 0); pe(8'h0D, 1, 0); pe(8'h0E, 2, 0); pe(8'h0F, 3, 1);
        send(32'h0F0E_0D0C, 4);
        chk("post_rst_idx0", 64'(el_idx), 64'd0);
        chk("post_rst_el0", 64'(el_out), 64'h0C);
        drain(4, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
